// File: rtl/spiking_weight_loader.sv
// Configuration sequencer for spiking_neural_network_xor: resets the network, streams a
// small (addr, cmd, arg) table into it, waits for the network to settle and reports its output.
// state | meaning: IDLE table writable / NRST network reset / PROG stream entries / SETTLE wait / SAMPLE capture
module spiking_weight_loader #(
  parameter int INT_WIDTH     = 4,
  parameter int FLOAT_WIDTH   = 2*INT_WIDTH,
  parameter int CMD_WIDTH     = 3,
  parameter int ADDR_WIDTH    = 3,
  parameter int DEPTH         = 8,
  parameter int IDX_WIDTH     = $clog2(DEPTH),
  parameter int SETTLE_CYCLES = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tbl_we,
  input  logic [IDX_WIDTH-1:0]   tbl_idx,
  input  logic [ADDR_WIDTH-1:0]  tbl_addr,
  input  logic [CMD_WIDTH-1:0]   tbl_cmd,
  input  logic [FLOAT_WIDTH-1:0] tbl_arg,
  input  logic [IDX_WIDTH:0]     num_entries,
  input  logic                   start,
  output logic                   busy,
  output logic                   net_rst,
  output logic [ADDR_WIDTH-1:0]  net_addr,
  output logic [CMD_WIDTH-1:0]   net_cmd,
  output logic [FLOAT_WIDTH-1:0] net_arg,
  input  logic                   net_out,
  output logic                   done,
  output logic                   result
);

  localparam int TMR_WIDTH = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_WIDTH:0]     L_DEPTH       = (IDX_WIDTH+1)'(DEPTH);
  localparam logic [TMR_WIDTH-1:0]   L_SETTLE_LAST = TMR_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0]  L_IDLE_ADDR   = '1;

  typedef enum logic [2:0] {S_IDLE, S_NRST, S_PROG, S_SETTLE, S_SAMPLE} state_t;

  state_t                 r_state;
  logic [IDX_WIDTH:0]     r_n;
  logic [IDX_WIDTH:0]     r_idx;
  logic [TMR_WIDTH-1:0]   r_tmr;
  logic                   r_busy;
  logic                   r_net_rst;
  logic [ADDR_WIDTH-1:0]  r_net_addr;
  logic [CMD_WIDTH-1:0]   r_net_cmd;
  logic [FLOAT_WIDTH-1:0] r_net_arg;
  logic                   r_done;
  logic                   r_result;

  logic [ADDR_WIDTH-1:0]  r_tbl_addr [DEPTH];
  logic [CMD_WIDTH-1:0]   r_tbl_cmd  [DEPTH];
  logic [FLOAT_WIDTH-1:0] r_tbl_arg  [DEPTH];

  logic                   w_tbl_wr;
  logic [IDX_WIDTH:0]     w_n_clamped;
  logic [IDX_WIDTH-1:0]   w_rd_idx;

  assign w_tbl_wr    = tbl_we && (r_state == S_IDLE) && ({1'b0, tbl_idx} < L_DEPTH);
  assign w_n_clamped = (num_entries > L_DEPTH) ? L_DEPTH : num_entries;
  assign w_rd_idx    = r_idx[IDX_WIDTH-1:0];

  // Table is plain storage: no reset, contents undefined until written.
  always_ff @(posedge clk) begin
    if (w_tbl_wr) begin
      r_tbl_addr[tbl_idx] <= tbl_addr;
      r_tbl_cmd[tbl_idx]  <= tbl_cmd;
      r_tbl_arg[tbl_idx]  <= tbl_arg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_idx      <= '0;
      r_tmr      <= '0;
      r_busy     <= 1'b0;
      r_net_rst  <= 1'b0;
      r_net_addr <= L_IDLE_ADDR;
      r_net_cmd  <= '0;
      r_net_arg  <= '0;
      r_done     <= 1'b0;
      r_result   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n       <= w_n_clamped;
            r_state   <= S_NRST;
            r_busy    <= 1'b1;
            r_net_rst <= 1'b1;
          end
        end
        S_NRST: begin
          r_net_rst <= 1'b0;
          if (r_n != '0) begin
            // Entry 0 is loaded here so it is on the bus during the first PROG cycle.
            r_state    <= S_PROG;
            r_net_addr <= r_tbl_addr[0];
            r_net_cmd  <= r_tbl_cmd[0];
            r_net_arg  <= r_tbl_arg[0];
            r_idx      <= (IDX_WIDTH+1)'(1);
          end else begin
            r_state <= S_SETTLE;
            r_tmr   <= L_SETTLE_LAST;
          end
        end
        S_PROG: begin
          if (r_idx == r_n) begin
            r_state    <= S_SETTLE;
            r_tmr      <= L_SETTLE_LAST;
            r_net_addr <= L_IDLE_ADDR;
            r_net_cmd  <= '0;
            r_net_arg  <= '0;
          end else begin
            r_net_addr <= r_tbl_addr[w_rd_idx];
            r_net_cmd  <= r_tbl_cmd[w_rd_idx];
            r_net_arg  <= r_tbl_arg[w_rd_idx];
            r_idx      <= r_idx + 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_tmr == '0) begin
            r_state  <= S_SAMPLE;
            r_done   <= 1'b1;
            r_result <= net_out;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_SAMPLE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_idx   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign net_rst  = r_net_rst;
  assign net_addr = r_net_addr;
  assign net_cmd  = r_net_cmd;
  assign net_arg  = r_net_arg;
  assign done     = r_done;
  assign result   = r_result;

endmodule

// File: tb/tb_spiking_weight_loader.sv
// Scoreboard bench for spiking_weight_loader; the network is stood in for by net_out = in1 ^ in2.
module tb_spiking_weight_loader;

  logic       clk;
  logic       rst;
  logic       tbl_we;
  logic [2:0] tbl_idx;
  logic [2:0] tbl_addr;
  logic [2:0] tbl_cmd;
  logic [7:0] tbl_arg;
  logic [3:0] num_entries;
  logic       start;
  logic       busy;
  logic       net_rst;
  logic [2:0] net_addr;
  logic [2:0] net_cmd;
  logic [7:0] net_arg;
  logic       net_out;
  logic       done;
  logic       result;
  logic       in1, in2;

  assign net_out = in1 ^ in2;

  spiking_weight_loader dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
    .tbl_cmd(tbl_cmd), .tbl_arg(tbl_arg), .num_entries(num_entries), .start(start),
    .busy(busy), .net_rst(net_rst), .net_addr(net_addr), .net_cmd(net_cmd),
    .net_arg(net_arg), .net_out(net_out), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [2:0] a; logic [2:0] c; logic [7:0] g; int t; } wr_t;
  typedef struct { logic r; int t; } dn_t;

  wr_t exp_wr[$];
  dn_t exp_done[$];
  int  exp_nrst[$];

  logic [2:0] m_a [8];
  logic [2:0] m_c [8];
  logic [7:0] m_g [8];

  int n_cmp = 0;
  int n_bad = 0;
  int n_done_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected events whenever the DUT presents one.
  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    int  t;
    if (rst) begin
      if (net_rst) begin
        if (exp_nrst.size() == 0) chk("nrst_unexpected", 1, 0);
        else begin
          t = exp_nrst.pop_front();
          chk("nrst_cycle", cyc, t);
          chk("busy_at_nrst", 32'(busy), 1);
        end
      end
      if (net_addr != 3'b111) begin
        if (exp_wr.size() == 0) chk("write_unexpected", 32'({net_addr, net_cmd, net_arg}), 32'h3800);
        else begin
          w = exp_wr.pop_front();
          chk("write_data", 32'({net_addr, net_cmd, net_arg}), 32'({w.a, w.c, w.g}));
          chk("write_cycle", cyc, w.t);
        end
      end else begin
        chk("idle_bus", 32'({net_cmd, net_arg}), 0);
      end
      if (done) begin
        n_done_seen++;
        if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          d = exp_done.pop_front();
          chk("done_result", 32'(result), 32'(d.r));
          chk("done_cycle", cyc, d.t);
          chk("busy_at_done", 32'(busy), 1);
        end
      end
    end
  end

  task automatic tbl_write(input int idx, input logic [2:0] a, input logic [2:0] c, input logic [7:0] g);
    tbl_we = 1'b1; tbl_idx = 3'(idx); tbl_addr = a; tbl_cmd = c; tbl_arg = g;
    m_a[idx] = a; m_c[idx] = c; m_g[idx] = g;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  // Starts a run in the current cycle and returns in the cycle right after done.
  task automatic run(input int ne, input bit a, input bit b, input bit extra, input bit wr0);
    int ts, n, L;
    ts = cyc;
    n  = (ne > 8) ? 8 : ne;
    L  = 1 + n + 25 + 1;
    in1 = a; in2 = b;
    num_entries = 4'(ne);
    start = 1'b1;
    if (wr0) begin
      tbl_we = 1'b1; tbl_idx = 3'd0; tbl_addr = 3'd0; tbl_cmd = 3'd5; tbl_arg = 8'hA5;
      m_a[0] = 3'd0; m_c[0] = 3'd5; m_g[0] = 8'hA5;
    end
    exp_nrst.push_back(ts + 1);
    for (int i = 0; i < n; i++) exp_wr.push_back('{m_a[i], m_c[i], m_g[i], ts + 2 + i});
    exp_done.push_back('{a ^ b, ts + L});
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      start = 1'b0; tbl_we = 1'b0;
      if (extra && (k == 5 || k == 20 || k == L)) start = 1'b1;
      if (extra && k == 5) begin
        tbl_we = 1'b1; tbl_idx = 3'd1; tbl_addr = 3'd6; tbl_cmd = 3'd7; tbl_arg = 8'h55;
        num_entries = 4'd0;
      end
    end
    start = 1'b0; tbl_we = 1'b0;
  endtask

  initial begin
    int ts, d0;
    rst = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_cmd = '0; tbl_arg = '0;
    num_entries = '0; start = 1'b0; in1 = 1'b0; in2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_net_rst", 32'(net_rst), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_bus", 32'({net_addr, net_cmd, net_arg}), 32'h3800);
    @(negedge clk);

    tbl_write(0, 3'd1, 3'd1, 8'h07);
    tbl_write(1, 3'd1, 3'd2, 8'h07);
    tbl_write(2, 3'd2, 3'd1, 8'h12);
    tbl_write(3, 3'd2, 3'd2, 8'h12);
    tbl_write(4, 3'd3, 3'd1, 8'hF1);
    tbl_write(5, 3'd3, 3'd2, 8'h0F);
    tbl_write(6, 3'd4, 3'd3, 8'h80);
    tbl_write(7, 3'd5, 3'd4, 8'h7F);

    run(6, 1'b0, 1'b1, 1'b0, 1'b0);
    run(6, 1'b0, 1'b0, 1'b0, 1'b0);
    run(6, 1'b1, 1'b0, 1'b0, 1'b0);
    run(6, 1'b1, 1'b1, 1'b0, 1'b0);
    run(0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(15, 1'b0, 1'b1, 1'b0, 1'b0);
    run(6, 1'b1, 1'b0, 1'b1, 1'b0);
    run(6, 1'b0, 1'b1, 1'b0, 1'b0);
    run(6, 1'b1, 1'b0, 1'b0, 1'b1);

    // Abort a run mid-PROG with an asynchronous reset.
    ts = cyc;
    in1 = 1'b0; in2 = 1'b1; num_entries = 4'd6;
    exp_nrst.push_back(ts + 1);
    for (int i = 0; i < 6; i++) exp_wr.push_back('{m_a[i], m_c[i], m_g[i], ts + 2 + i});
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_net_addr", 32'(net_addr), 32'h7);
    chk("midrst_net_rst", 32'(net_rst), 0);
    chk("midrst_result", 32'(result), 0);
    chk("midrst_cmd_arg", 32'({net_cmd, net_arg}), 0);
    chk("midrst_writes_seen", 32'(exp_wr.size()), 4);
    exp_wr.delete();
    exp_nrst.delete();
    d0 = n_done_seen;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_after_reset", n_done_seen - d0, 0);

    run(6, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 50 && (exp_wr.size() + exp_done.size() + exp_nrst.size()) != 0; k++)
      @(negedge clk);
    chk("pending_writes", 32'(exp_wr.size()), 0);
    chk("pending_done", 32'(exp_done.size()), 0);
    chk("pending_nrst", 32'(exp_nrst.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spiking_weight_loader.md
Name: spiking_weight_loader

Overview:
- Upstream configuration sequencer for spiking_neural_network_xor. Replaces hand-written bench programming.
- Holds a small table of (addr, cmd, arg) weight writes. On start it:
  - pulses the network reset,
  - streams the table into the network's addr/cmd/cmd_arg bus, one entry per cycle,
  - waits a settle interval,
  - samples the network output and reports it with a done pulse.

Parameters:
- INT_WIDTH, 4, integer part width; must match the network.
- FLOAT_WIDTH, 2*INT_WIDTH, width of the weight argument (signed).
- CMD_WIDTH, 3, network command width.
- ADDR_WIDTH, 3, network address width; all-ones address is the idle/no-op address.
- DEPTH, 8, number of table entries.
- IDX_WIDTH, $clog2(DEPTH), table index width.
- SETTLE_CYCLES, 25, cycles waited after the last write before sampling; must be at least 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- tbl_we  in  1  table write strobe.
- tbl_idx  in  IDX_WIDTH  table entry index.
- tbl_addr  in  ADDR_WIDTH  entry network address.
- tbl_cmd  in  CMD_WIDTH  entry network command.
- tbl_arg  in  FLOAT_WIDTH  entry signed weight.
- num_entries  in  IDX_WIDTH+1  number of entries to stream; sampled at start.
- start  in  1  one-cycle request to run a sequence.
- busy  out  1  sequence in progress.
- net_rst  out  1  active-high reset to the network.
- net_addr  out  ADDR_WIDTH  network address bus.
- net_cmd  out  CMD_WIDTH  network command bus.
- net_arg  out  FLOAT_WIDTH  network weight argument.
- net_out  in  1  network spike/XOR output.
- done  out  1  one-cycle pulse; result is valid.
- result  out  1  net_out value captured in the SAMPLE cycle.

Behaviour:
- Reset values (async on rst=0):
  - state=IDLE, busy=0, net_rst=0, done=0, result=0.
  - net_addr=all-ones, net_cmd=0, net_arg=0, all counters 0.
  - Table contents are not reset; they are undefined until written.
- All outputs are registered.

Table writes:
- Accepted only in IDLE: tbl_we=1 writes entry tbl_idx on the clock edge.
- tbl_we is ignored while busy=1; no error flag.
- tbl_idx >= DEPTH: write dropped.

FSM states: IDLE, NRST, PROG, SETTLE, SAMPLE.
- IDLE:
  - start=1 latches n = min(num_entries, DEPTH), then goes to NRST.
  - Otherwise stays in IDLE.
- NRST (exactly 1 cycle): net_rst=1, busy=1.
  - Next state is PROG if n>0, else SETTLE.
- PROG (n cycles, entry i in cycle i):
  - net_addr/net_cmd/net_arg = entry i, in index order 0..n-1.
  - After entry n-1, go to SETTLE.
- SETTLE (exactly SETTLE_CYCLES cycles): net_addr=all-ones, net_cmd=0, net_arg=0.
- SAMPLE (1 cycle): result<=net_out, done=1, busy=1, then back to IDLE.

Busy, start and timing rules:
- busy=1 in every non-IDLE state and 0 in IDLE.
- start is ignored while busy, including the SAMPLE cycle. A new start is accepted from the first IDLE cycle.
- Latency from the start edge to the done pulse is 1 + n + SETTLE_CYCLES + 1 cycles.
- result holds its value until the next SAMPLE or reset.
- net_arg is passed through bit-exact. No sign extension or saturation is applied; the table stores FLOAT_WIDTH bits as written.

Boundary conditions:
- num_entries=0: goes NRST -> SETTLE directly; no writes are issued.
- num_entries > DEPTH: clamped to DEPTH.
- Changing num_entries during a run has no effect.
- start and tbl_we in the same IDLE cycle: the write takes effect and the sequence starts. Entry 0 is first driven two cycles later, so the new data is used.
- Reset mid-sequence: immediate return to IDLE with all reset values.
  - net_rst drops to 0 asynchronously.
  - net_addr goes to all-ones asynchronously.
  - No done pulse is produced.

Test Plan:
- Reset check: rst=0 mid-PROG -> within the same cycle busy=0, net_addr=3'b111, net_rst=0; done never pulses.
- XOR program:
  - Table: 0:(1,1,8'h07), 1:(1,2,8'h07), 2:(2,1,8'h12), 3:(2,2,8'h12), 4:(3,1,8'hF1), 5:(3,2,8'h0F); num_entries=6; network wired in1=0, in2=1.
  - Required: net_rst high exactly 1 cycle after start, then the 6 entries in order, 1 cycle each.
  - Required: done exactly 33 cycles after the start edge (1+6+25+1), with result=1.
- Repeat all four (in1,in2) combinations -> result = in1^in2 each time: 0,1,1,0.
- num_entries=0 -> no cycle with net_addr != all-ones; done 27 cycles after start.
- num_entries=15 with DEPTH=8 -> exactly 8 entries streamed; done at 35 cycles.
- start pulses at cycles 5 and 20 of a run, plus tbl_we during PROG -> single done, table unchanged. A start in the cycle after done launches a second run.
